// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, state encoding and request record for the per-core memory sequencer.
package gpu_mem_pkg;
    localparam int N_CORES  = 16;
    localparam int N_BANKS  = 16;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int TMO_W    = 8;
    localparam int BANK_W   = 4;
    localparam int BANK_MSB = ADDR_W - 1;
    localparam int BANK_LSB = ADDR_W - BANK_W;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } req_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } core_req_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_MSB:BANK_LSB];
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side and arbiter-side buses of the memory sequencer, one lane per core.
interface mem_access_ctrl_if;
    import gpu_mem_pkg::*;

    logic [N_CORES-1:0]                            core_req;
    logic [N_CORES-1:0]                            core_we;
    logic [N_CORES-1:0][ADDR_W-1:0]                core_addr;
    logic [N_CORES-1:0][DATA_W-1:0]                core_wdata;
    logic [N_CORES-1:0]                            core_ready;
    logic [N_CORES-1:0]                            core_done;
    logic [N_CORES-1:0]                            core_err;
    logic [N_CORES-1:0][DATA_W-1:0]                core_rdata;
    logic [N_CORES-1:0]                            arb_read;
    logic [N_CORES-1:0]                            arb_write;
    logic [N_CORES-1:0][ADDR_W-1:0]                arb_addr;
    logic [N_CORES-1:0][DATA_W-1:0]                arb_wdata;
    logic [N_BANKS-1:0][N_CORES-1:0]               arb_finish;
    logic [N_BANKS-1:0][N_CORES-1:0][DATA_W-1:0]   arb_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, arb_finish, arb_rdata,
        output core_ready, core_done, core_err, core_rdata,
               arb_read, arb_write, arb_addr, arb_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, arb_finish, arb_rdata,
        input  core_ready, core_done, core_err, core_rdata,
               arb_read, arb_write, arb_addr, arb_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_fsm.sv
// One core's request sequencer: latches the access, waits for its bank's finish, times out lost requests.
module core_req_fsm
    import gpu_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  core_req_t         i_cmd,
    input  logic              i_hit,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic              o_read,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [BANK_W-1:0] o_bank
);
    req_state_e        r_state, w_state;
    core_req_t         r_cmd, w_cmd;
    logic              r_ready, w_ready;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic              r_read, w_read;
    logic              r_write, w_write;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic [TMO_W-1:0]  r_timer, w_timer;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state;
            r_cmd   <= w_cmd;
            r_ready <= w_ready;
            r_done  <= w_done;
            r_err   <= w_err;
            r_read  <= w_read;
            r_write <= w_write;
            r_rdata <= w_rdata;
            r_timer <= w_timer;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cmd   = r_cmd;
        w_ready = r_ready;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_read  = r_read;
        w_write = r_write;
        w_rdata = r_rdata;
        w_timer = r_timer;
        unique case (r_state)
            IDLE: if (i_req) begin
                w_cmd   = i_cmd;
                w_timer = '0;
                w_read  = ~i_cmd.we;
                w_write = i_cmd.we;
                w_ready = 1'b0;
                w_state = BUSY;
            end
            // A finish on the timeout cycle still completes normally.
            BUSY: if (i_hit) begin
                if (!r_cmd.we) w_rdata = i_rdata;
                w_read  = 1'b0;
                w_write = 1'b0;
                w_done  = 1'b1;
                w_state = DONE;
            end else if (r_timer == TMO_MAX) begin
                w_read  = 1'b0;
                w_write = 1'b0;
                w_done  = 1'b1;
                w_err   = 1'b1;
                w_state = DONE;
            end else begin
                w_timer = r_timer + TMO_W'(1);
            end
            DONE: begin
                w_ready = 1'b1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    assign o_ready = r_ready;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_read  = r_read;
    assign o_write = r_write;
    assign o_addr  = r_cmd.addr;
    assign o_wdata = r_cmd.wdata;
    assign o_rdata = r_rdata;
    assign o_bank  = bank_of(r_cmd.addr);
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer top: one FSM per core plus the finish/rdata select from each core's latched bank.
module mem_access_ctrl
    import gpu_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_access_ctrl_if.slave  bus
);
    logic [N_CORES-1:0][BANK_W-1:0] w_bank;
    logic [N_CORES-1:0]             w_hit;
    logic [N_CORES-1:0][DATA_W-1:0] w_bank_rdata;
    logic [N_CORES-1:0]             w_ready, w_done, w_err, w_read, w_write;
    logic [N_CORES-1:0][ADDR_W-1:0] w_addr;
    logic [N_CORES-1:0][DATA_W-1:0] w_wdata, w_rdata;

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        core_req_t w_cmd;

        assign w_cmd           = '{we: bus.core_we[c], addr: bus.core_addr[c], wdata: bus.core_wdata[c]};
        // Only the bank this core addressed can complete it.
        assign w_hit[c]        = bus.arb_finish[w_bank[c]][c];
        assign w_bank_rdata[c] = bus.arb_rdata[w_bank[c]][c];

        core_req_fsm u_fsm (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_req   (bus.core_req[c]),
            .i_cmd   (w_cmd),
            .i_hit   (w_hit[c]),
            .i_rdata (w_bank_rdata[c]),
            .o_ready (w_ready[c]),
            .o_done  (w_done[c]),
            .o_err   (w_err[c]),
            .o_read  (w_read[c]),
            .o_write (w_write[c]),
            .o_addr  (w_addr[c]),
            .o_wdata (w_wdata[c]),
            .o_rdata (w_rdata[c]),
            .o_bank  (w_bank[c])
        );
    end

    assign bus.core_ready = w_ready;
    assign bus.core_done  = w_done;
    assign bus.core_err   = w_err;
    assign bus.core_rdata = w_rdata;
    assign bus.arb_read   = w_read;
    assign bus.arb_write  = w_write;
    assign bus.arb_addr   = w_addr;
    assign bus.arb_wdata  = w_wdata;
endmodule
